alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single clocked ALU between two requesters, e.g. the decode/execute path and a debug/test port.
- Each requester hands over one operation (opcode and two 32-bit operands) through a valid/ready handshake.
- The block arbitrates round-robin, drives the ALU ports, waits out the ALU latency and captures result and flags.
- It returns one tagged response per accepted request, with backpressure on the response channel.

Parameters:
- ALU_LATENCY, 1: clock edges from operands present at ALU inputs to result/flags valid at ALU outputs (>=1).
- NUM_OPS, 18: highest legal opcode; 0 is NOP; any opcode above NUM_OPS is illegal.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 holds an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  5  ALU opcode.
- req0_a  in  32  operand num1.
- req0_b  in  32  operand num2.
- req1_valid / req1_ready / req1_op / req1_a / req1_b: same as requester 0.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index owning the response.
- rsp_result  out  32  captured ALU result.
- rsp_flags  out  4  captured ALU flags {N,Z,C,V}.
- rsp_err  out  1  illegal opcode; the ALU was not used.
- alu_instruction  out  5  to ALU instruction.
- alu_num1  out  32  to ALU num1.
- alu_num2  out  32  to ALU num2.
- alu_result  in  32  from ALU result.
- alu_flags  in  4  from ALU flags.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values (asynchronous, on rst_n low): state=IDLE, rr_last=1 (so req0 wins the first tie), all rsp_* = 0, alu_instruction=0, alu_num1=0, alu_num2=0, latency counter=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqX_ready is combinational: high only in IDLE, only for the granted requester, and only when that requester's valid is high. At most one ready is high per cycle.
  - Grant: if one requester is valid, it wins. If both are valid, the requester not equal to rr_last wins. rr_last updates on every accept.
  - On accept: latch op, a, b and id.
  - Legal opcode 1..NUM_OPS: go to EXEC.
  - Opcode 0 or opcode > NUM_OPS: go directly to RESP with rsp_err=1, rsp_result=0, rsp_flags=0. The ALU is never driven.
- EXEC:
  - Lasts exactly ALU_LATENCY+1 cycles.
  - alu_instruction, alu_num1 and alu_num2 carry the latched values for every EXEC cycle. They are 0 in all other states.
  - On the closing edge of the last EXEC cycle, capture alu_result and alu_flags into rsp_result and rsp_flags. Set rsp_err=0 and rsp_id=latched id, then go to RESP.
- RESP:
  - rsp_valid=1, with all rsp_* fields held stable until rsp_valid && rsp_ready.
  - Then go to IDLE next cycle. rsp_valid drops; rsp_* data holds its last value.
  - There is no accept in the same cycle as the response handshake.
- Latency with ALU_LATENCY=1:
  - Accept in cycle T; EXEC in T+1 and T+2; rsp_valid first high in T+3.
  - Best-case issue interval is 4 cycles.
  - For an illegal opcode, rsp_valid is high in T+1.
- Starvation: a requester whose valid stays high is served within one other transaction.
- Reset mid-operation (EXEC or RESP): the transaction is dropped with no response, and the ALU ports go to 0 immediately. Requesters must reissue.
- Requester valid dropping before accept is legal; nothing is latched.
- No arithmetic is done here; widths pass through unchanged.

Decomposition:
- Shared package alu_pkg:
  - opcode constants ANDS=1, ORRS=2, MVNS=3, EORS=4, ADCS=5, ADDS=6, SBCS=7, SUB=8, MULS=9, LSRS=10, LSLS=11, ASR=12, ROR=13, UXTB=14, UXTH=15, SXTB=16, SXTH=17, CMP=18;
  - OP_W=5, DATA_W=32, FLAG_W=4;
  - flag bit indices N=3, Z=2, C=1, V=0.
- One sub-module, rr_arbiter2: two valid inputs plus an enable produce a one-hot grant, and it owns the rr_last register.

Test Plan:
- Single request: req0 ANDS a=15 b=10 with ALU model latency 1 -> req0_ready in cycle T; ALU sees op 1 in T+1..T+2; rsp_valid in T+3 with result=10, rsp_id=0, rsp_err=0.
- Tie: req0 ADDS 5+4 and req1 SUB 16-4, both valid from reset -> req0 served first (result 9), then req1 (result 12, id 1). Repeat with both valid again -> req0 served first, because rr_last=1 after req1.
- Illegal opcode: req1 op=25 -> rsp_valid one cycle after accept with rsp_err=1, result 0, flags 0; alu_instruction stays 0 throughout.
- Backpressure: rsp_ready held low 5 cycles during an ORRS 500|5 response -> rsp_result=501 held stable; req0_ready and req1_ready stay low; busy=1 until the handshake.
- Reset in EXEC: assert rst_n=0 during the second EXEC cycle of MULS 5*4 -> all outputs 0 asynchronously; no response after release; the next request is served normally.
- Latency parameter: ALU_LATENCY=3 with LSLS 13<<3 -> EXEC lasts 4 cycles and rsp_result=104.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sharing logic: opcode map, data
// widths, flag bit positions and the arbiter FSM state encoding.
package alu_pkg;

    localparam int OP_W   = 5;
    localparam int DATA_W = 32;
    localparam int FLAG_W = 4;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [OP_W-1:0] NOP  = 5'd0;
    localparam logic [OP_W-1:0] ANDS = 5'd1;
    localparam logic [OP_W-1:0] ORRS = 5'd2;
    localparam logic [OP_W-1:0] MVNS = 5'd3;
    localparam logic [OP_W-1:0] EORS = 5'd4;
    localparam logic [OP_W-1:0] ADCS = 5'd5;
    localparam logic [OP_W-1:0] ADDS = 5'd6;
    localparam logic [OP_W-1:0] SBCS = 5'd7;
    localparam logic [OP_W-1:0] SUB  = 5'd8;
    localparam logic [OP_W-1:0] MULS = 5'd9;
    localparam logic [OP_W-1:0] LSRS = 5'd10;
    localparam logic [OP_W-1:0] LSLS = 5'd11;
    localparam logic [OP_W-1:0] ASR  = 5'd12;
    localparam logic [OP_W-1:0] ROR  = 5'd13;
    localparam logic [OP_W-1:0] UXTB = 5'd14;
    localparam logic [OP_W-1:0] UXTH = 5'd15;
    localparam logic [OP_W-1:0] SXTB = 5'd16;
    localparam logic [OP_W-1:0] SXTH = 5'd17;
    localparam logic [OP_W-1:0] CMP  = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    // NOP and anything past the top of the opcode map never reach the ALU.
    function automatic logic op_legal(input logic [OP_W-1:0] op, input int unsigned num_ops);
        return (op != '0) && (32'(op) <= num_ops);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the requester that did not win last time
// takes a tie. rr_last resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic rr_last;

    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (valid == 2'b11) begin
                grant = rr_last ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (grant != 2'b00) begin
            rr_last <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one clocked ALU between two valid/ready requesters and returns one
// tagged, backpressured response per accepted operation.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for a request; the granted requester sees ready
// ST_EXEC | ALU ports driven with the latched operation, ALU_LATENCY+1 cycles
// ST_RESP | rsp_valid high, response held until rsp_ready
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned NUM_OPS     = 18
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              rsp_err,

    output logic [OP_W-1:0]   alu_instruction,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flags,

    output logic              busy
);

    localparam int CNT_W = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);

    state_t            state;
    logic [1:0]        grant;
    logic              lat_id;
    logic [CNT_W-1:0]  lat_cnt;

    logic              sel_id;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == ST_IDLE),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign sel_id = grant[1];
    assign sel_op = grant[1] ? req1_op : req0_op;
    assign sel_a  = grant[1] ? req1_a  : req0_a;
    assign sel_b  = grant[1] ? req1_b  : req0_b;

    assign busy = (state != ST_IDLE);

    // The ALU port registers double as the operation latch: they are only
    // non-zero while in ST_EXEC, so reset clears the ALU inputs at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            lat_id          <= 1'b0;
            lat_cnt         <= '0;
            alu_instruction <= '0;
            alu_num1        <= '0;
            alu_num2        <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= 1'b0;
            rsp_result      <= '0;
            rsp_flags       <= '0;
            rsp_err         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        lat_id <= sel_id;
                        if (op_legal(sel_op, NUM_OPS)) begin
                            alu_instruction <= sel_op;
                            alu_num1        <= sel_a;
                            alu_num2        <= sel_b;
                            lat_cnt         <= CNT_W'(ALU_LATENCY);
                            state           <= ST_EXEC;
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_id     <= sel_id;
                            rsp_result <= '0;
                            rsp_flags  <= '0;
                            rsp_err    <= 1'b1;
                            state      <= ST_RESP;
                        end
                    end
                end

                ST_EXEC: begin
                    if (lat_cnt == '0) begin
                        rsp_valid       <= 1'b1;
                        rsp_id          <= lat_id;
                        rsp_result      <= alu_result;
                        rsp_flags       <= alu_flags;
                        rsp_err         <= 1'b0;
                        alu_instruction <= '0;
                        alu_num1        <= '0;
                        alu_num2        <= '0;
                        state           <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, multi-cycle
// corner sequences, and a randomized run against a cycle-arithmetic model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [31:0] rsp_result, alu_num1, alu_num2, alu_result;
    logic [3:0]  rsp_flags, alu_flags;
    logic [4:0]  alu_instruction;

    logic        t_req0_valid, t_req0_ready, t_req1_valid, t_req1_ready;
    logic [4:0]  t_req0_op, t_req1_op;
    logic [31:0] t_req0_a, t_req0_b, t_req1_a, t_req1_b;
    logic        t_rsp_valid, t_rsp_ready, t_rsp_id, t_rsp_err, t_busy;
    logic [31:0] t_rsp_result, t_alu_num1, t_alu_num2, t_alu_result;
    logic [3:0]  t_rsp_flags, t_alu_flags;
    logic [4:0]  t_alu_instruction;

    alu_arbiter #(.ALU_LATENCY(L1), .NUM_OPS(18)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_instruction(alu_instruction), .alu_num1(alu_num1), .alu_num2(alu_num2),
        .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
    );

    alu_arbiter #(.ALU_LATENCY(L3), .NUM_OPS(18)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_op(t_req0_op), .req0_a(t_req0_a), .req0_b(t_req0_b),
        .req1_valid(t_req1_valid), .req1_ready(t_req1_ready), .req1_op(t_req1_op), .req1_a(t_req1_a), .req1_b(t_req1_b),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id), .rsp_result(t_rsp_result),
        .rsp_flags(t_rsp_flags), .rsp_err(t_rsp_err),
        .alu_instruction(t_alu_instruction), .alu_num1(t_alu_num1), .alu_num2(t_alu_num2),
        .alu_result(t_alu_result), .alu_flags(t_alu_flags), .busy(t_busy)
    );

    // Behavioural ALU: returns {flags, result}.
    function automatic logic [35:0] alu_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic [3:0]  f;
        logic        c, v;
        w = '0; r = '0; c = 1'b0; v = 1'b0; f = '0;
        case (op)
            ANDS: r = a & b;
            ORRS: r = a | b;
            MVNS: r = ~b;
            EORS: r = a ^ b;
            ADCS, ADDS: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SBCS, SUB, CMP: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            MULS: r = a * b;
            LSRS: r = a >> b[4:0];
            LSLS: r = a << b[4:0];
            ASR:  r = $signed(a) >>> b[4:0];
            ROR:  r = (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}));
            UXTB: r = {24'd0, b[7:0]};
            UXTH: r = {16'd0, b[15:0]};
            SXTB: r = {{24{b[7]}}, b[7:0]};
            SXTH: r = {{16{b[15]}}, b[15:0]};
            default: r = '0;
        endcase
        f[FLAG_N] = r[31];
        f[FLAG_Z] = (r == 32'd0);
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return {f, r};
    endfunction

    always @(posedge clk) {alu_flags, alu_result} <= alu_calc(alu_instruction, alu_num1, alu_num2);

    logic [35:0] t_pipe [3];
    always @(posedge clk) begin
        t_pipe[0] <= alu_calc(t_alu_instruction, t_alu_num1, t_alu_num2);
        t_pipe[1] <= t_pipe[0];
        t_pipe[2] <= t_pipe[1];
    end
    assign {t_alu_flags, t_alu_result} = t_pipe[2];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_req(input int id, input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic apply_reset();
        cycle_start();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        t_req0_valid = 1'b0; t_req1_valid = 1'b0;
        cycle_start();
        cycle_start();
        rst_n = 1'b1;
    endtask

    // Called in the accept cycle; steps until rsp_valid or a budget expires.
    task automatic expect_rsp(input string name, input logic [1:0] drop, input logic exp_id,
                              input logic [31:0] exp_res, input logic [3:0] exp_flags, input logic exp_err,
                              input logic [4:0] exp_op, input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input int exp_lat);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            cycle_start();
            if (n == 0) begin
                if (drop[0]) req0_valid = 1'b0;
                if (drop[1]) req1_valid = 1'b0;
            end
            settle();
            n++;
            if (rsp_valid) begin
                seen = 1'b1;
            end else begin
                check({name, " alu_op"}, alu_instruction, exp_op);
                check({name, " alu_num1"}, alu_num1, exp_a);
                check({name, " alu_num2"}, alu_num2, exp_b);
                check({name, " busy"}, busy, 1'b1);
            end
        end
        check({name, " latency"}, n, exp_lat);
        if (seen) begin
            check({name, " id"}, rsp_id, exp_id);
            check({name, " result"}, rsp_result, exp_res);
            check({name, " flags"}, rsp_flags, exp_flags);
            check({name, " err"}, rsp_err, exp_err);
            check({name, " alu idle in resp"}, alu_instruction, 5'd0);
        end
    endtask

    typedef struct {
        bit          id;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        logic [3:0]  exp_flags;
        bit          exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input string name, input vec_t v);
        logic [1:0] drop;
        drop = v.id ? 2'b10 : 2'b01;
        cycle_start();
        drive_req(int'(v.id), 1'b1, v.op, v.a, v.b);
        rsp_ready = 1'b1;
        settle();
        check({name, " ready0"}, req0_ready, !v.id);
        check({name, " ready1"}, req1_ready, v.id);
        check({name, " busy at accept"}, busy, 1'b0);
        expect_rsp(name, drop, v.id, v.exp_res, v.exp_flags, v.exp_err,
                   v.exp_err ? 5'd0 : v.op, v.exp_err ? 32'd0 : v.a, v.exp_err ? 32'd0 : v.b,
                   v.exp_err ? 1 : L1 + 2);
        cycle_start();
        settle();
        check({name, " rsp_valid drops"}, rsp_valid, 1'b0);
        check({name, " busy after"}, busy, 1'b0);
    endtask

    // Random-phase model state
    bit          p_v [2];
    logic [4:0]  p_op [2];
    logic [31:0] p_a [2];
    logic [31:0] p_b [2];

    initial begin
        int          n, n_exec, spurious, winner, m_last, m_acc, m_id;
        bit          seen, m_out, m_legal, exp_rv;
        logic [4:0]  m_op;
        logic [31:0] m_a, m_b;
        logic [35:0] m_exp;

        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        t_req0_valid = 0; t_req0_op = 0; t_req0_a = 0; t_req0_b = 0;
        t_req1_valid = 0; t_req1_op = 0; t_req1_a = 0; t_req1_b = 0;
        rsp_ready = 1'b1;
        t_rsp_ready = 1'b1;

        vecs[0]  = '{1'b0, ANDS,  32'd15,         32'd10,  32'd10,         4'b0000, 1'b0};
        vecs[1]  = '{1'b1, EORS,  32'hFF,         32'hFF,  32'd0,          4'b0100, 1'b0};
        vecs[2]  = '{1'b0, SUB,   32'd3,          32'd5,   32'hFFFF_FFFE,  4'b1000, 1'b0};
        vecs[3]  = '{1'b1, ADDS,  32'hFFFF_FFFF,  32'd1,   32'd0,          4'b0110, 1'b0};
        vecs[4]  = '{1'b0, ADDS,  32'h7FFF_FFFF,  32'd1,   32'h8000_0000,  4'b1001, 1'b0};
        vecs[5]  = '{1'b1, CMP,   32'd7,          32'd7,   32'd0,          4'b0110, 1'b0};
        vecs[6]  = '{1'b0, 5'd0,  32'd123,        32'd456, 32'd0,          4'b0000, 1'b1};
        vecs[7]  = '{1'b1, 5'd19, 32'd123,        32'd456, 32'd0,          4'b0000, 1'b1};
        vecs[8]  = '{1'b0, CMP,   32'd10,         32'd3,   32'd7,          4'b0010, 1'b0};
        vecs[9]  = '{1'b1, 5'd31, 32'd1,          32'd2,   32'd0,          4'b0000, 1'b1};
        vecs[10] = '{1'b1, ASR,   32'h8000_0000,  32'd4,   32'hF800_0000,  4'b1000, 1'b0};
        vecs[11] = '{1'b0, MULS,  32'd5,          32'd4,   32'd20,         4'b0000, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        check("reset rsp_valid", rsp_valid, 1'b0);
        check("reset rsp_id", rsp_id, 1'b0);
        check("reset rsp_result", rsp_result, 32'd0);
        check("reset rsp_flags", rsp_flags, 4'd0);
        check("reset rsp_err", rsp_err, 1'b0);
        check("reset alu_instruction", alu_instruction, 5'd0);
        check("reset alu_num1", alu_num1, 32'd0);
        check("reset alu_num2", alu_num2, 32'd0);
        check("reset busy", busy, 1'b0);
        check("reset ready0", req0_ready, 1'b0);
        check("reset ready1", req1_ready, 1'b0);

        for (int i = 0; i < 12; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // ALU_LATENCY=3 instance
        cycle_start();
        t_req0_valid = 1'b1; t_req0_op = LSLS; t_req0_a = 32'd13; t_req0_b = 32'd3;
        settle();
        check("L3 ready", t_req0_ready, 1'b1);
        n = 0; n_exec = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            cycle_start();
            if (n == 0) t_req0_valid = 1'b0;
            settle();
            n++;
            if (t_rsp_valid) seen = 1'b1;
            else if (t_alu_instruction == LSLS) n_exec++;
        end
        check("L3 exec cycles", n_exec, 4);
        check("L3 latency", n, 5);
        check("L3 result", t_rsp_result, 32'd104);
        check("L3 err", t_rsp_err, 1'b0);

        // Tie from reset, then tie again after req1 was served last
        apply_reset();
        drive_req(0, 1'b1, ADDS, 32'd5, 32'd4);
        drive_req(1, 1'b1, SUB, 32'd16, 32'd4);
        rsp_ready = 1'b1;
        settle();
        check("tie grant0", req0_ready, 1'b1);
        check("tie not1", req1_ready, 1'b0);
        expect_rsp("tie first", 2'b01, 1'b0, 32'd9, 4'b0000, 1'b0, ADDS, 32'd5, 32'd4, 3);
        cycle_start();
        settle();
        check("tie grant1", req1_ready, 1'b1);
        expect_rsp("tie second", 2'b10, 1'b1, 32'd12, 4'b0010, 1'b0, SUB, 32'd16, 32'd4, 3);
        cycle_start();
        drive_req(0, 1'b1, ADDS, 32'd5, 32'd4);
        drive_req(1, 1'b1, SUB, 32'd16, 32'd4);
        settle();
        check("tie2 grant0", req0_ready, 1'b1);
        check("tie2 not1", req1_ready, 1'b0);
        expect_rsp("tie2 first", 2'b01, 1'b0, 32'd9, 4'b0000, 1'b0, ADDS, 32'd5, 32'd4, 3);
        cycle_start();
        settle();
        check("tie2 grant1", req1_ready, 1'b1);
        expect_rsp("tie2 second", 2'b10, 1'b1, 32'd12, 4'b0010, 1'b0, SUB, 32'd16, 32'd4, 3);

        // Backpressure, with an illegal opcode from req1 waiting behind it
        cycle_start();
        rsp_ready = 1'b0;
        drive_req(0, 1'b1, ORRS, 32'd500, 32'd5);
        settle();
        check("bp accept", req0_ready, 1'b1);
        expect_rsp("bp", 2'b01, 1'b0, 32'd501, 4'b0000, 1'b0, ORRS, 32'd500, 32'd5, 3);
        for (int i = 0; i < 5; i++) begin
            cycle_start();
            drive_req(1, 1'b1, 5'd25, 32'd7, 32'd9);
            settle();
            check("bp hold valid", rsp_valid, 1'b1);
            check("bp hold result", rsp_result, 32'd501);
            check("bp ready0 low", req0_ready, 1'b0);
            check("bp ready1 low", req1_ready, 1'b0);
            check("bp busy", busy, 1'b1);
        end
        cycle_start();
        rsp_ready = 1'b1;
        settle();
        check("bp handshake valid", rsp_valid, 1'b1);
        cycle_start();
        settle();
        check("bp released", rsp_valid, 1'b0);
        check("bp data holds", rsp_result, 32'd501);
        check("bp idle", busy, 1'b0);
        check("illegal accept", req1_ready, 1'b1);
        check("illegal alu at accept", alu_instruction, 5'd0);
        expect_rsp("illegal", 2'b10, 1'b1, 32'd0, 4'b0000, 1'b1, 5'd0, 32'd0, 32'd0, 1);

        // Reset during the second EXEC cycle
        cycle_start();
        cycle_start();
        drive_req(0, 1'b1, MULS, 32'd5, 32'd4);
        settle();
        check("rst accept", req0_ready, 1'b1);
        cycle_start();
        req0_valid = 1'b0;
        settle();
        check("rst exec1 op", alu_instruction, MULS);
        cycle_start();
        settle();
        check("rst exec2 op", alu_instruction, MULS);
        rst_n = 1'b0;
        #1;
        check("rst async alu_op", alu_instruction, 5'd0);
        check("rst async num1", alu_num1, 32'd0);
        check("rst async num2", alu_num2, 32'd0);
        check("rst async busy", busy, 1'b0);
        check("rst async rsp_valid", rsp_valid, 1'b0);
        cycle_start();
        rst_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (rsp_valid) spurious++;
            cycle_start();
        end
        check("rst no response", spurious, 0);
        run_vec("after rst", '{1'b0, MULS, 32'd5, 32'd4, 32'd20, 4'b0000, 1'b0});

        // Randomized traffic against the timing/arbitration model
        apply_reset();
        p_v[0] = 0; p_v[1] = 0;
        m_out = 0; m_last = 1; m_acc = 0; m_id = 0; m_op = 0; m_a = 0; m_b = 0; m_legal = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!p_v[i] && $urandom_range(0, 3) == 0) begin
                    p_v[i] = 1'b1;
                    p_op[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 18));
                    p_a[i] = $urandom;
                    p_b[i] = $urandom;
                end else if (p_v[i] && !m_out && $urandom_range(0, 15) == 0) begin
                    p_v[i] = 1'b0;
                end
            end
            drive_req(0, p_v[0], p_op[0], p_a[0], p_b[0]);
            drive_req(1, p_v[1], p_op[1], p_a[1], p_b[1]);
            rsp_ready = ($urandom_range(0, 3) != 0);
            settle();

            winner = -1;
            exp_rv = 1'b0;
            if (m_out) begin
                exp_rv = (cyc >= m_acc + (m_legal ? L1 + 2 : 1));
                check("rnd alu_op", alu_instruction, (m_legal && cyc <= m_acc + L1 + 1) ? m_op : 5'd0);
                check("rnd alu_num1", alu_num1, (m_legal && cyc <= m_acc + L1 + 1) ? m_a : 32'd0);
                check("rnd alu_num2", alu_num2, (m_legal && cyc <= m_acc + L1 + 1) ? m_b : 32'd0);
            end else begin
                if (p_v[0] && p_v[1]) winner = (m_last == 1) ? 0 : 1;
                else if (p_v[0]) winner = 0;
                else if (p_v[1]) winner = 1;
                check("rnd alu idle", alu_instruction, 5'd0);
            end
            check("rnd ready0", req0_ready, winner == 0);
            check("rnd ready1", req1_ready, winner == 1);
            check("rnd busy", busy, m_out);
            check("rnd rsp_valid", rsp_valid, exp_rv);
            if (exp_rv) begin
                m_exp = m_legal ? alu_calc(m_op, m_a, m_b) : 36'd0;
                check("rnd rsp_id", rsp_id, m_id[0]);
                check("rnd rsp_result", rsp_result, m_exp[31:0]);
                check("rnd rsp_flags", rsp_flags, m_exp[35:32]);
                check("rnd rsp_err", rsp_err, !m_legal);
            end

            if (m_out) begin
                if (exp_rv && rsp_ready) m_out = 1'b0;
            end else if (winner >= 0) begin
                m_out = 1'b1;
                m_acc = cyc;
                m_id = winner;
                m_op = p_op[winner];
                m_a = p_a[winner];
                m_b = p_b[winner];
                m_legal = (p_op[winner] >= 5'd1) && (p_op[winner] <= 5'd18);
                m_last = winner;
                p_v[winner] = 1'b0;
            end
            cycle_start();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
